// File: rtl/vc_wrr_scheduler_pkg.sv
// Shared definitions for the virtual-channel weighted round-robin scheduler:
// channel count, field widths, FSM state encoding and the weight-sanitising
// helper used when weights are latched.
package vc_wrr_scheduler_pkg;

  localparam int TL_NUM_CH   = 4;
  localparam int TL_WEIGHT_W = 3;
  localparam int TL_CNT_W    = 5;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } sched_state_e;

  // A zero weight would starve the channel; it is treated as weight 1.
  function automatic logic [TL_WEIGHT_W-1:0] fix_weight(input logic [TL_WEIGHT_W-1:0] w);
    return (w == '0) ? TL_WEIGHT_W'(1) : w;
  endfunction

endpackage

// File: rtl/vc_wrr_scheduler_rr_pick4.sv
// rr_pick4: combinational round-robin picker for 4 requesters.
//  eligible  in  4  request vector
//  ptr       in  2  current pointer
//  found     out 1  some bit of eligible is set
//  idx       out 2  first set bit scanning ptr+1, ptr+2, ptr+3, ptr (wrapping)
module rr_pick4 (
  input  logic [3:0] eligible,
  input  logic [1:0] ptr,
  output logic       found,
  output logic [1:0] idx
);

  logic [1:0] cand;

  // Walk offsets from farthest to nearest so the nearest hit is written last
  // and wins. Offset 4 wraps to ptr itself, the lowest priority.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = '0;
    for (int k = 4; k >= 1; k--) begin
      cand = ptr + 2'(k);
      if (eligible[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/vc_wrr_scheduler.sv
// vc_wrr_scheduler: weighted round-robin grant between 4 middle FIFOs and
// their output FIFOs. One channel is popped per cycle at most; the matching
// push (and demux select) follows one cycle later to cover FIFO read latency.
//  clk          in   system clock
//  reset        in   synchronous, active-high
//  init         in   load weights and enter INIT
//  weights      in   ch i weight at [i*WEIGHT_W +: WEIGHT_W]
//  empty        in   middle FIFO empty flags
//  almost_full  in   output FIFO almost-full flags
//  pop          out  one-hot pop to middle FIFO
//  push         out  one-hot push to output FIFO (pop delayed 1)
//  sel          out  channel index aligned with push
//  sched_state  out  RESET/INIT/IDLE/ACTIVE
//  grant_cnt    out  per-channel grant counters, ch i at [i*CNT_W +: CNT_W]
module vc_wrr_scheduler
  import vc_wrr_scheduler_pkg::*;
#(
  parameter int NUM_CH   = TL_NUM_CH,
  parameter int WEIGHT_W = TL_WEIGHT_W,
  parameter int CNT_W    = TL_CNT_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         init,
  input  logic [NUM_CH*WEIGHT_W-1:0]   weights,
  input  logic [NUM_CH-1:0]            empty,
  input  logic [NUM_CH-1:0]            almost_full,
  output logic [NUM_CH-1:0]            pop,
  output logic [NUM_CH-1:0]            push,
  output logic [1:0]                   sel,
  output logic [1:0]                   sched_state,
  output logic [NUM_CH*CNT_W-1:0]      grant_cnt
);

  sched_state_e                         state_q;
  logic [NUM_CH-1:0][WEIGHT_W-1:0]      wt_in, wt_q;
  logic [NUM_CH-1:0][CNT_W-1:0]         cnt_q;
  logic [WEIGHT_W-1:0]                  credit_q, credit_nxt;
  logic [1:0]                           ptr_q, ptr_nxt;
  logic [1:0]                           pop_idx_q;
  logic [NUM_CH-1:0]                    pop_q, push_q;
  logic [1:0]                           sel_q;
  logic [NUM_CH-1:0]                    eligible;
  logic                                 pick_found;
  logic [1:0]                           pick_idx;
  logic                                 grant_vld;
  logic [1:0]                           grant_idx;

  assign wt_in    = weights;
  assign eligible = ~empty & ~almost_full;

  rr_pick4 u_pick (
    .eligible (eligible),
    .ptr      (ptr_q),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  // Stay on ptr while it has credit; otherwise hand over to the next eligible
  // channel, which spends one unit of its fresh credit on this very grant.
  always_comb begin
    grant_vld  = 1'b0;
    grant_idx  = ptr_q;
    credit_nxt = credit_q;
    ptr_nxt    = ptr_q;
    if (state_q == ST_ACTIVE && !init) begin
      if (eligible[ptr_q] && credit_q != '0) begin
        grant_vld  = 1'b1;
        grant_idx  = ptr_q;
        credit_nxt = credit_q - 1'b1;
      end else if (pick_found) begin
        grant_vld  = 1'b1;
        grant_idx  = pick_idx;
        ptr_nxt    = pick_idx;
        credit_nxt = wt_q[pick_idx] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RESET;
      wt_q      <= '0;
      cnt_q     <= '0;
      credit_q  <= '0;
      ptr_q     <= '0;
      pop_idx_q <= '0;
      pop_q     <= '0;
      push_q    <= '0;
      sel_q     <= '0;
    end else begin
      // Push stage always completes whatever was popped last cycle.
      push_q <= pop_q;
      sel_q  <= pop_idx_q;
      pop_q  <= '0;
      case (state_q)
        ST_RESET: begin
          if (init) state_q <= ST_INIT;
        end
        ST_INIT: begin
          for (int i = 0; i < NUM_CH; i++) wt_q[i] <= fix_weight(wt_in[i]);
          cnt_q    <= '0;
          ptr_q    <= '0;
          credit_q <= fix_weight(wt_in[0]);
          if (!init) state_q <= ST_IDLE;
        end
        ST_IDLE: begin
          if (init)           state_q <= ST_INIT;
          else if (|eligible) state_q <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (init) begin
            state_q <= ST_INIT;
          end else if (grant_vld) begin
            pop_q            <= NUM_CH'(1) << grant_idx;
            pop_idx_q        <= grant_idx;
            cnt_q[grant_idx] <= cnt_q[grant_idx] + 1'b1;
            ptr_q            <= ptr_nxt;
            credit_q         <= credit_nxt;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_RESET;
      endcase
    end
  end

  assign pop         = pop_q;
  assign push        = push_q;
  assign sel         = sel_q;
  assign sched_state = state_q;
  assign grant_cnt   = cnt_q;

endmodule
